wb_trace_buffer: RTL and testbench
==================================

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 Parameter: DEPTH, 16, number of trace records held; power of two, 4..256.
REQ-002 Parameter: OVF_W, 16, width of the dropped-record counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 trace_en  input  1  capture enable; 0 means retire events are ignored, not counted as drops.
REQ-006 wb_valid  input  1  one instruction retires from MEM/WB this cycle.
REQ-007 wb_pc  input  32  PC of the retiring instruction.
REQ-008 wb_rd  input  5  destination register index.
REQ-009 wb_data  input  32  writeback value.
REQ-010 wb_regwrite  input  1  register-write control of the retiring instruction.
REQ-011 tr_valid  output  1  head record available.
REQ-012 tr_ready  input  1  consumer accepts head record.
REQ-013 tr_cycle  output  32  cycle stamp of head record.
REQ-014 tr_pc  output  32  PC of head record.
REQ-015 tr_rd  output  5  rd of head record.
REQ-016 tr_data  output  32  writeback value of head record.
REQ-017 tr_we  output  1  effective register write of head record.
REQ-018 count  output  $clog2(DEPTH)+1  records currently held, 0..DEPTH.
REQ-019 full  output  1  count == DEPTH.
REQ-020 ovf_cnt  output  OVF_W  records dropped because the buffer was full.

Function
REQ-021 Free-running 32-bit cycle counter shall be 0 in the first cycle after reset release, increment by 1 every cycle, and wrap 0xFFFFFFFF -> 0.
REQ-022 Push shall occur when trace_en && wb_valid and (!full || pop this cycle).
REQ-023 The stored record shall be {cycle counter value of the push cycle, wb_pc, wb_rd, wb_data, we}, with we = wb_regwrite && (wb_rd != 0).
REQ-024 Pop shall occur when tr_valid && tr_ready; tr_valid shall equal (count != 0).
REQ-025 tr_* fields shall reflect the record at the read pointer. tr_* shall be don't-care while tr_valid = 0.
REQ-026 Latency: a record pushed into an empty buffer shall appear with tr_valid = 1 in the next cycle, not the same cycle.
REQ-027 Pointers shall wrap modulo DEPTH. Records shall leave in strict push order.
REQ-028 Simultaneous push and pop shall leave count unchanged. This includes the case full = 1, where the push is accepted and no drop occurs.
REQ-029 Push attempt while full without a pop shall drop the record and increment ovf_cnt. ovf_cnt shall saturate at all-ones.
REQ-030 Pop while empty shall have no effect. tr_ready is ignored when tr_valid = 0.
REQ-031 tr_valid shall not depend combinationally on tr_ready. tr_* shall remain stable while tr_valid && !tr_ready.

Reset
REQ-032 When rst = 0 at a clock edge, the following shall be cleared to 0: pointers, count, ovf_cnt and cycle counter. tr_valid and full shall then read 0.
REQ-033 Reset asserted mid-operation shall discard all held records. A push or pop on the reset cycle shall be ignored.
REQ-034 Storage array contents need no reset.

Structure
REQ-035 Shared package trace_pkg shall hold the trace record struct typedef (cycle, pc, rd, data, we) and the constant TRACE_REC_W = 102.
REQ-036 Storage, pointers and count shall live in one sub-module, sync_fifo, parameterised by width and depth.
REQ-037 The cycle counter, record formation, drop logic and ovf_cnt shall live in the top level.

Verification
REQ-038 Reset, then a push in cycle 3 with pc=0x00000008, rd=5, data=0x0000000A, regwrite=1 -> next cycle: tr_valid=1, tr_cycle=3, tr_we=1, count=1.
REQ-039 Retire with rd=0, regwrite=1 -> tr_we=0. Retire with trace_en=0 -> no record and ovf_cnt unchanged.
REQ-040 Hold tr_ready=0 and push 18 records -> count=16, full=1, ovf_cnt=2. Then drain 16 records -> PCs in push order and records 17/18 absent.
REQ-041 Full buffer with push and pop in the same cycle -> count stays 16, ovf_cnt unchanged, new record is last out.
REQ-042 Preload the cycle counter near wrap (force 0xFFFFFFFE) and push on consecutive cycles -> stamps 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-043 Reset asserted with 5 records held -> next cycle count=0, tr_valid=0, ovf_cnt=0, cycle counter=0.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared trace record type and helpers
package trace_pkg;

   localparam int TRACE_REC_W = 102;

   typedef struct packed {
      logic [31:0] cycle;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
   } trace_rec_t;

   // A write to x0 is architecturally a no-op, so it is never flagged as a write.
   function automatic trace_rec_t make_rec(input logic [31:0] cycle,
                                           input logic [31:0] pc,
                                           input logic [4:0]  rd,
                                           input logic [31:0] data,
                                           input logic        regwrite);
      trace_rec_t r;
      r.cycle = cycle;
      r.pc    = pc;
      r.rd    = rd;
      r.data  = data;
      r.we    = regwrite && (rd != 5'd0);
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO holding storage, pointers and occupancy
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_en, rd_en;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   // Accept a pop only when data is held; a write into a full FIFO is allowed if a pop frees the slot.
   always_comb begin
      rd_en   = pop_i && !empty_o;
      wr_en   = push_i && (!full_o || rd_en);
      wptr_d  = wr_en ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = rd_en ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is not reset; stale entries are never visible because count gates validity.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - retire trace capture with cycle stamps and drop counting
module wb_trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int OVF_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trace_en,
   input  logic                     wb_valid,
   input  logic [31:0]              wb_pc,
   input  logic [4:0]               wb_rd,
   input  logic [31:0]              wb_data,
   input  logic                     wb_regwrite,
   output logic                     tr_valid,
   input  logic                     tr_ready,
   output logic [31:0]              tr_cycle,
   output logic [31:0]              tr_pc,
   output logic [4:0]               tr_rd,
   output logic [31:0]              tr_data,
   output logic                     tr_we,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic [OVF_W-1:0]         ovf_cnt
);

   logic [31:0]            cyc_q, cyc_d;
   logic [OVF_W-1:0]       ovf_q, ovf_d;
   logic                   push_req, pop, push, drop;
   logic                   fifo_empty;
   trace_rec_t             wr_rec, rd_rec;
   logic [TRACE_REC_W-1:0] rd_bits;

   assign tr_valid = !fifo_empty;
   assign rd_rec   = rd_bits;
   assign tr_cycle = rd_rec.cycle;
   assign tr_pc    = rd_rec.pc;
   assign tr_rd    = rd_rec.rd;
   assign tr_data  = rd_rec.data;
   assign tr_we    = rd_rec.we;
   assign ovf_cnt  = ovf_q;

   // A retire is dropped only when the buffer is full and nothing leaves this cycle.
   always_comb begin
      push_req = trace_en && wb_valid;
      pop      = tr_valid && tr_ready;
      push     = push_req && (!full || pop);
      drop     = push_req && full && !pop;
      wr_rec   = make_rec(cyc_q, wb_pc, wb_rd, wb_data, wb_regwrite);
      cyc_d    = cyc_q + 32'd1;
      ovf_d    = ovf_q;
      if (drop && (ovf_q != '1)) begin
         ovf_d = ovf_q + OVF_W'(1);
      end
   end

   // Free-running cycle stamp and saturating drop counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cyc_q <= '0;
         ovf_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         ovf_q <= ovf_d;
      end
   end

   sync_fifo #(
      .WIDTH (TRACE_REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_rec),
      .rdata_o (rd_bits),
      .count_o (count),
      .full_o  (full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - randomized and directed checks of wb_trace_buffer against a queue model
module tb_wb_trace_buffer;

   localparam int DEPTH = 16;
   localparam int OVF_W = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int OVF_MAX = (1 << OVF_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              trace_en, wb_valid, wb_regwrite, tr_ready;
   logic [31:0]       wb_pc, wb_data;
   logic [4:0]        wb_rd;
   logic              tr_valid, tr_we, full;
   logic [31:0]       tr_cycle, tr_pc, tr_data;
   logic [4:0]        tr_rd;
   logic [CW-1:0]     count;
   logic [OVF_W-1:0]  ovf_cnt;

   typedef struct {
      logic [31:0] cyc;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
   } mrec_t;

   mrec_t       mq[$];
   int          m_ovf;
   logic [31:0] m_cyc;
   int          errors = 0;
   int          checks = 0;
   bit          cmp_en = 1'b0;

   wb_trace_buffer #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
      .clk(clk), .rst(rst), .trace_en(trace_en), .wb_valid(wb_valid),
      .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .wb_regwrite(wb_regwrite),
      .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_cycle(tr_cycle), .tr_pc(tr_pc),
      .tr_rd(tr_rd), .tr_data(tr_data), .tr_we(tr_we), .count(count), .full(full),
      .ovf_cnt(ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update from the inputs seen at the edge, using the state from before the edge.
   task automatic model_update();
      bit    was_full, pop;
      mrec_t r;
      if (!rst) begin
         mq.delete();
         m_ovf = 0;
         m_cyc = 32'd0;
      end else begin
         was_full = (mq.size() == DEPTH);
         pop      = (mq.size() != 0) && tr_ready;
         if (pop) void'(mq.pop_front());
         if (trace_en && wb_valid) begin
            if (!was_full || pop) begin
               r.cyc  = m_cyc;
               r.pc   = wb_pc;
               r.rd   = wb_rd;
               r.data = wb_data;
               r.we   = wb_regwrite && (wb_rd != 5'd0);
               mq.push_back(r);
            end else if (m_ovf < OVF_MAX) begin
               m_ovf++;
            end
         end
         m_cyc = m_cyc + 32'd1;
      end
   endtask

   // Every cycle: outputs must agree with the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m.tr_valid", 32'(tr_valid), 32'(mq.size() != 0));
         chk("m.count", 32'(count), 32'(mq.size()));
         chk("m.full", 32'(full), 32'(mq.size() == DEPTH));
         chk("m.ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
         chk("m.cycle", dut.cyc_q, m_cyc);
         if (mq.size() != 0) begin
            chk("m.tr_cycle", tr_cycle, mq[0].cyc);
            chk("m.tr_pc", tr_pc, mq[0].pc);
            chk("m.tr_rd", 32'(tr_rd), 32'(mq[0].rd));
            chk("m.tr_data", tr_data, mq[0].data);
            chk("m.tr_we", 32'(tr_we), 32'(mq[0].we));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      trace_en = 1'b0; wb_valid = 1'b0; wb_regwrite = 1'b0; tr_ready = 1'b0;
      wb_pc = '0; wb_rd = '0; wb_data = '0;
   endtask

   task automatic drive_push(input logic [31:0] pc, input logic [4:0] rd,
                             input logic [31:0] data, input logic rw);
      trace_en = 1'b1; wb_valid = 1'b1;
      wb_pc = pc; wb_rd = rd; wb_data = data; wb_regwrite = rw;
   endtask

   task automatic no_push();
      trace_en = 1'b0; wb_valid = 1'b0;
   endtask

   initial begin
      int rdy_pct;
      rst = 1'b0;
      idle();
      @(negedge clk);
      tick();
      tick();
      cmp_en = 1'b1;
      rst = 1'b1;
      chk("rst.tr_valid", 32'(tr_valid), 32'd0);
      chk("rst.count", 32'(count), 32'd0);
      chk("rst.full", 32'(full), 32'd0);
      chk("rst.ovf", 32'(ovf_cnt), 32'd0);

      // First stamped push in cycle 3 after release.
      tick(); tick(); tick();
      drive_push(32'h8, 5'd5, 32'hA, 1'b1);
      tick();
      no_push();
      chk("first.tr_valid", 32'(tr_valid), 32'd1);
      chk("first.tr_cycle", tr_cycle, 32'd3);
      chk("first.tr_we", 32'(tr_we), 32'd1);
      chk("first.count", 32'(count), 32'd1);

      // x0 destination clears we; disabled capture neither stores nor counts a drop.
      drive_push(32'h10, 5'd0, 32'h55, 1'b1);
      tr_ready = 1'b1;
      tick();
      no_push();
      tr_ready = 1'b0;
      chk("x0.count", 32'(count), 32'd1);
      chk("x0.tr_pc", tr_pc, 32'h10);
      chk("x0.tr_we", 32'(tr_we), 32'd0);
      drive_push(32'h14, 5'd3, 32'h1, 1'b1);
      trace_en = 1'b0;
      tick();
      no_push();
      chk("dis.count", 32'(count), 32'd1);
      chk("dis.ovf", 32'(ovf_cnt), 32'd0);
      tr_ready = 1'b1;
      tick();
      tr_ready = 1'b0;
      chk("dis.drained", 32'(count), 32'd0);

      // Overfill by two, then drain in order.
      for (int i = 0; i < 18; i++) begin
         drive_push(32'h100 + 32'(4 * i), 5'(i + 1), 32'(i), 1'b1);
         tick();
      end
      no_push();
      chk("ovf.count", 32'(count), 32'd16);
      chk("ovf.full", 32'(full), 32'd1);
      chk("ovf.ovf", 32'(ovf_cnt), 32'd2);
      tr_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("ovf.drain_pc", tr_pc, 32'h100 + 32'(4 * i));
         tick();
      end
      tr_ready = 1'b0;
      chk("ovf.empty", 32'(count), 32'd0);

      // Push and pop together while full.
      for (int i = 0; i < 16; i++) begin
         drive_push(32'h200 + 32'(4 * i), 5'd1, 32'd0, 1'b0);
         tick();
      end
      drive_push(32'h999, 5'd2, 32'd7, 1'b1);
      tr_ready = 1'b1;
      tick();
      no_push();
      tr_ready = 1'b0;
      chk("fpp.count", 32'(count), 32'd16);
      chk("fpp.ovf", 32'(ovf_cnt), 32'd2);
      tr_ready = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      chk("fpp.last_pc", tr_pc, 32'h999);
      tick();
      tr_ready = 1'b0;

      // Drop counter saturation.
      for (int i = 0; i < 36; i++) begin
         drive_push(32'h300 + 32'(4 * i), 5'd4, 32'd0, 1'b1);
         tick();
      end
      no_push();
      chk("sat.ovf", 32'(ovf_cnt), 32'(OVF_MAX));
      tr_ready = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      tr_ready = 1'b0;

      // Cycle counter wrap.
      force dut.cyc_q = 32'hFFFF_FFFE;
      release dut.cyc_q;
      m_cyc = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         drive_push(32'h400 + 32'(4 * i), 5'd6, 32'd0, 1'b1);
         tick();
      end
      no_push();
      tr_ready = 1'b1;
      chk("wrap.stamp0", tr_cycle, 32'hFFFF_FFFE);
      tick();
      chk("wrap.stamp1", tr_cycle, 32'hFFFF_FFFF);
      tick();
      chk("wrap.stamp2", tr_cycle, 32'h0000_0000);
      tick();
      tr_ready = 1'b0;

      // Reset with records held; push and pop on the reset cycle are ignored.
      for (int i = 0; i < 5; i++) begin
         drive_push(32'h500 + 32'(4 * i), 5'd7, 32'd0, 1'b1);
         tick();
      end
      rst = 1'b0;
      tr_ready = 1'b1;
      tick();
      rst = 1'b1;
      no_push();
      tr_ready = 1'b0;
      chk("mrst.count", 32'(count), 32'd0);
      chk("mrst.tr_valid", 32'(tr_valid), 32'd0);
      chk("mrst.ovf", 32'(ovf_cnt), 32'd0);
      chk("mrst.cycle", dut.cyc_q, 32'd0);

      // Randomized traffic with varying consumer pressure and occasional reset.
      rdy_pct = 50;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) begin
            case ($urandom_range(0, 2))
               0:       rdy_pct = 10;
               1:       rdy_pct = 50;
               default: rdy_pct = 90;
            endcase
         end
         trace_en    = ($urandom_range(0, 9) < 8);
         wb_valid    = ($urandom_range(0, 9) < 7);
         wb_pc       = $urandom;
         wb_rd       = 5'($urandom);
         wb_data     = $urandom;
         wb_regwrite = 1'($urandom);
         tr_ready    = ($urandom_range(0, 99) < rdy_pct);
         rst         = !($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b1;
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
